// File: rtl/dbus_phrase_pack.sv
// dbus_phrase_pack
// Write-phrase packer that sits after the data-bus up-shifter. It merges
// successive narrow, lane-aligned write beats into one phrase register with
// per-byte enables. It then offers each completed phrase to the write port
// over a valid/ready handshake.
//
// Ports
//   sys_clk    system clock; all state changes on the rising edge
//   resetl     asynchronous, active-low reset
//   in_valid   write beat present
//   in_ready   beat accepted when in_valid & in_ready at the clock edge
//   in_data    lane-aligned write data, lane i = bits[8i+7:8i]
//   in_ofs     first byte lane of the beat
//   in_siz     beat size: 0=1, 1=2, 2=4, 3=8 bytes
//   in_last    close the phrase after this beat
//   flush      close the current partial phrase
//   out_valid  phrase available
//   out_ready  consumer takes the phrase when out_valid & out_ready
//   out_data   packed phrase; lanes that are not enabled read as zero
//   out_be     byte enables, bit i = lane i
//   trunc      sticky flag: a beat ran past the top lane (cleared by reset only)

module dbus_phrase_pack #(
    parameter int NLANE = 8
) (
    input  logic                        sys_clk,
    input  logic                        resetl,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [8*NLANE-1:0]          in_data,
    input  logic [$clog2(NLANE)-1:0]    in_ofs,
    input  logic [1:0]                  in_siz,
    input  logic                        in_last,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [8*NLANE-1:0]          out_data,
    output logic [NLANE-1:0]            out_be,
    output logic                        trunc
);

    // Room for the widest beat (8 bytes) starting at the top lane.
    localparam int WIDE = NLANE + 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [8*NLANE-1:0]  data;
    logic [NLANE-1:0]    be;
    logic [3:0]          lane_cnt;
    logic [WIDE-1:0]     span;
    logic [WIDE-1:0]     span_sh;
    logic [NLANE-1:0]    mask;
    logic                over;
    logic                accept;
    logic                close;

    // Beat mask. It is built wider than the phrase so that bytes falling past
    // the top lane can be detected and dropped.
    always_comb begin
        lane_cnt = 4'd1 << in_siz;
        span     = (WIDE'(1) << lane_cnt) - WIDE'(1);
        span_sh  = span << in_ofs;
        mask     = span_sh[NLANE-1:0];
        over     = |span_sh[WIDE-1:NLANE];
    end

    assign accept = in_valid & in_ready;
    assign close  = ((be | mask) == {NLANE{1'b1}}) | in_last | flush;

    // State register.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state. A flush with no beat closes only a partial phrase.
    // An overlapping beat simply waits until upstream closes the phrase.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = close ? DRAIN : FILL;
                end
            end
            FILL: begin
                if (flush || (accept && close)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs. in_ready is low for the whole drain, so a beat offered during
    // the drain handshake is taken on the following cycle at the earliest.
    always_comb begin
        out_valid = (state == DRAIN);
        in_ready  = (state != DRAIN) && ((be & mask) == '0);
    end

    // Phrase datapath. Lanes are cleared when a phrase drains, so lanes that
    // are not enabled always read back as zero.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            data  <= '0;
            be    <= '0;
            trunc <= 1'b0;
        end else if (state == DRAIN) begin
            if (out_ready) begin
                data <= '0;
                be   <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NLANE; i++) begin
                if (mask[i]) begin
                    data[8*i +: 8] <= in_data[8*i +: 8];
                end
            end
            be <= be | mask;
            if (over) begin
                trunc <= 1'b1;
            end
        end
    end

    assign out_data = data;
    assign out_be   = be;

endmodule

// File: tb/tb_dbus_phrase_pack.sv
// tb_dbus_phrase_pack
// Directed bench for dbus_phrase_pack. The bench drives inputs and samples
// outputs 1 time unit after each rising clock edge. Every expected value is a
// hand-computed constant.

module tb_dbus_phrase_pack;

    logic        sys_clk;
    logic        resetl;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [2:0]  in_ofs;
    logic [1:0]  in_siz;
    logic        in_last;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_be;
    logic        trunc;

    int total = 0;
    int bad   = 0;

    dbus_phrase_pack #(.NLANE(8)) dut (
        .sys_clk   (sys_clk),
        .resetl    (resetl),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ofs    (in_ofs),
        .in_siz    (in_siz),
        .in_last   (in_last),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_be    (out_be),
        .trunc     (trunc)
    );

    // Free-running clock, period 10.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Drives one set of beat-side inputs.
    task automatic applyStimulus(input logic v, input logic [2:0] ofs, input logic [1:0] siz,
                                 input logic [63:0] d, input logic last, input logic fl);
        in_valid = v;
        in_ofs   = ofs;
        in_siz   = siz;
        in_data  = d;
        in_last  = last;
        flush    = fl;
    endtask

    // Compares one observed value against its expected constant.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advances to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Directed sequence.
    initial begin
        logic [63:0] d;

        resetl    = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b0, 3'd0, 2'd0, 64'h0, 1'b0, 1'b0);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_be", out_be, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_trunc", trunc, 0);
        step();
        step();
        resetl = 1'b1;
        step();
        checkOutput("rst_in_ready", in_ready, 1);

        $display("[TB] byte beats into one full phrase");
        for (int i = 0; i < 8; i++) begin
            d = 64'(8'h11 * (i + 1)) << (8 * i);
            applyStimulus(1'b1, 3'(i), 2'd0, d, 1'b0, 1'b0);
            #0;
            checkOutput("byte_in_ready", in_ready, 1);
            checkOutput("byte_out_valid_pre", out_valid, 0);
            step();
        end
        applyStimulus(1'b0, 3'd0, 2'd0, 64'h0, 1'b0, 1'b0);
        checkOutput("byte_out_valid", out_valid, 1);
        checkOutput("byte_out_data", out_data, 64'h8877665544332211);
        checkOutput("byte_out_be", out_be, 8'hFF);
        checkOutput("byte_drain_in_ready", in_ready, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput("byte_after_valid", out_valid, 0);
        checkOutput("byte_after_be", out_be, 0);
        checkOutput("byte_after_ready", in_ready, 1);

        $display("[TB] long beat with in_last, then held drain");
        applyStimulus(1'b1, 3'd4, 2'd2, 64'hDEADBEEF_00000000, 1'b1, 1'b0);
        step();
        applyStimulus(1'b1, 3'd0, 2'd0, 64'h0000_0000_0000_0077, 1'b0, 1'b0);
        checkOutput("long_out_valid", out_valid, 1);
        checkOutput("long_out_be", out_be, 8'hF0);
        checkOutput("long_out_data", out_data, 64'hDEADBEEF_00000000);
        for (int c = 0; c < 5; c++) begin
            step();
            checkOutput("hold_out_valid", out_valid, 1);
            checkOutput("hold_out_be", out_be, 8'hF0);
            checkOutput("hold_out_data", out_data, 64'hDEADBEEF_00000000);
            checkOutput("hold_in_ready", in_ready, 0);
        end
        applyStimulus(1'b0, 3'd0, 2'd0, 64'h0, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput("release_out_valid", out_valid, 0);
        checkOutput("release_in_ready", in_ready, 1);
        checkOutput("release_out_data", out_data, 0);

        $display("[TB] overlapping word beats with flush");
        applyStimulus(1'b1, 3'd2, 2'd1, 64'h0000_0000_BBAA_0000, 1'b0, 1'b0);
        step();
        checkOutput("ovl_first_be", out_be, 8'h0C);
        applyStimulus(1'b1, 3'd3, 2'd1, 64'h0000_00DD_CC00_0000, 1'b0, 1'b0);
        #0;
        checkOutput("ovl_stall_ready", in_ready, 0);
        step();
        checkOutput("ovl_stall_be", out_be, 8'h0C);
        checkOutput("ovl_stall_valid", out_valid, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("ovl_flush_valid", out_valid, 1);
        checkOutput("ovl_flush_be", out_be, 8'h0C);
        checkOutput("ovl_flush_data", out_data, 64'h0000_0000_BBAA_0000);
        checkOutput("ovl_drain_ready", in_ready, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput("ovl_idle_valid", out_valid, 0);
        checkOutput("ovl_idle_ready", in_ready, 1);
        step();
        applyStimulus(1'b0, 3'd0, 2'd0, 64'h0, 1'b0, 1'b0);
        checkOutput("ovl_second_be", out_be, 8'h18);
        checkOutput("ovl_second_valid", out_valid, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("ovl_second_out_valid", out_valid, 1);
        checkOutput("ovl_second_data", out_data, 64'h0000_00DD_CC00_0000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        $display("[TB] truncated beat");
        checkOutput("trunc_before", trunc, 0);
        applyStimulus(1'b1, 3'd5, 2'd3, 64'h1234_5600_0000_0000, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 3'd0, 2'd0, 64'h0, 1'b0, 1'b0);
        checkOutput("trunc_set", trunc, 1);
        checkOutput("trunc_be", out_be, 8'hE0);
        checkOutput("trunc_fill_valid", out_valid, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("trunc_out_valid", out_valid, 1);
        checkOutput("trunc_out_data", out_data, 64'h1234_5600_0000_0000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        applyStimulus(1'b1, 3'd0, 2'd0, 64'h0000_0000_0000_0042, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 3'd0, 2'd0, 64'h0, 1'b0, 1'b0);
        checkOutput("trunc_next_be", out_be, 8'h01);
        checkOutput("trunc_next_data", out_data, 64'h42);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput("trunc_sticky", trunc, 1);

        $display("[TB] reset in the middle of a phrase");
        applyStimulus(1'b1, 3'd0, 2'd1, 64'h0000_0000_0000_BEEF, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 3'd0, 2'd0, 64'h0, 1'b0, 1'b0);
        checkOutput("midrst_be_before", out_be, 8'h03);
        resetl = 1'b0;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_out_be", out_be, 0);
        checkOutput("midrst_out_data", out_data, 0);
        checkOutput("midrst_trunc", trunc, 0);
        step();
        resetl = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checkOutput("midrst_no_phrase", out_valid, 0);
        end
        checkOutput("midrst_in_ready", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Backstop so the run always ends even if the sequence stalls.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: observed=running expected=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] timeout");
    end

endmodule
